// File: rtl/ofm_writeback_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ofm_writeback_sequencer_pkg
// Shared definitions for the OFM write-back path: the sequencer state encoding
// and the default geometry constants that the layer controller also uses.
// ----------------------------------------------------------------------------
package ofm_writeback_sequencer_pkg;

    // Sequencer states. DRAIN is the only state that presents write beats.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_e;

    localparam int DEF_NUM_LANES = 16;
    localparam int DEF_NUM_BEATS = 4;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DEPTH     = 65536;

endpackage

// File: rtl/ofm_writeback_sequencer_wrap_counter.sv
// ----------------------------------------------------------------------------
// wrap_counter
// Modulo-MOD up counter with enable, synchronous clear and a terminal flag.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   en_i     : advance by one; wraps to 0 after MOD-1
//   clr_i    : synchronous clear, wins over en_i
//   count_o  : current count, always in 0..MOD-1
//   term_o   : count_o == MOD-1
// ----------------------------------------------------------------------------
module wrap_counter #(
    parameter  int MOD = 4,
    localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Wrap on the terminal value explicitly so the count never leaves
    // 0..MOD-1, even when MOD is not a power of two.
    assign term_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = term_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ofm_writeback_sequencer.sv
// ----------------------------------------------------------------------------
// ofm_writeback_sequencer
// Detects a complete OFM group (all lanes valid) and serialises it as
// NUM_BEATS write beats into the next layer's RAM region.
//   clk, rst      : clock, asynchronous active-high reset
//   ofm_valid     : per-lane valid; a group starts when all lanes are valid
//   done_compute  : layer finished; aborts any burst and clears the offset
//   base_addr     : region base, stable during a layer
//   wr_ready      : sink accepts the presented beat this cycle
//   mux_sel       : OFM slice select for the current beat (0..NUM_BEATS-1)
//   addr_next_wr  : base_addr + registered offset (wraps within DEPTH words)
//   wr_en_next    : a beat is presented (high exactly while draining)
//   wr_data_valid : one-cycle pulse after the last beat of a group is accepted
//   busy          : sequencer state (1 = DRAIN); doubles as the FSM debug view
//   overflow_err  : sticky; a group arrived mid-burst and was dropped
//
// Handshake: a beat transfers on a cycle where wr_en_next and wr_ready are
// both high; while wr_ready is low the beat, its select and its address hold.
// ----------------------------------------------------------------------------
module ofm_writeback_sequencer
    import ofm_writeback_sequencer_pkg::*;
#(
    parameter  int NUM_LANES = DEF_NUM_LANES,
    parameter  int NUM_BEATS = DEF_NUM_BEATS,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DEPTH     = DEF_DEPTH,
    localparam int SEL_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] ofm_valid,
    input  logic                 done_compute,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 wr_ready,
    output logic [SEL_W-1:0]     mux_sel,
    output logic [ADDR_W-1:0]    addr_next_wr,
    output logic                 wr_en_next,
    output logic                 wr_data_valid,
    output logic                 busy,
    output logic                 overflow_err
);

    localparam int OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_state_e        state_q;
    wb_state_e        state_d;
    logic             grp_start;
    logic             acc;
    logic             last;
    logic             beat_term;
    logic [OFF_W-1:0] offset;
    logic             wdv_d;
    logic             wdv_q;
    logic             ovf_d;
    logic             ovf_q;

    assign grp_start  = &ofm_valid;
    assign wr_en_next = (state_q == DRAIN);
    assign acc        = wr_en_next & wr_ready;
    assign last       = acc & beat_term;

    // Both counters advance on an accepted beat. done_compute clears them,
    // and the clear wins, so a beat accepted on the abort cycle does not
    // move the offset.
    wrap_counter #(.MOD(NUM_BEATS)) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (acc),
        .clr_i   (done_compute),
        .count_o (mux_sel),
        .term_o  (beat_term)
    );

    wrap_counter #(.MOD(DEPTH)) u_offset_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (acc),
        .clr_i   (done_compute),
        .count_o (offset),
        .term_o  ()
    );

    always_comb begin
        state_d = state_q;
        wdv_d   = last & ~done_compute;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (grp_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A new group on the last beat chains straight on; any other
                // group arriving mid-burst is dropped and flagged.
                if (last && !grp_start) begin
                    state_d = IDLE;
                end
                if (grp_start && !last) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done_compute) begin
            state_d = IDLE;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wdv_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdv_q   <= wdv_d;
            ovf_q   <= ovf_d;
        end
    end

    // Zero-extend (or truncate) the offset; the sum wraps at ADDR_W bits.
    assign addr_next_wr  = base_addr + ADDR_W'(offset);
    assign busy          = wr_en_next;
    assign wr_data_valid = wdv_q;
    assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_ofm_writeback_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ofm_writeback_sequencer
// Two sequencers share one stimulus stream: the default geometry and a small
// one (3 beats, 6-word region, 12-bit address) that exercises a
// non-power-of-two beat count, region wrap and address truncation. A
// transaction-level model predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_ofm_writeback_sequencer;

    localparam int NL = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NL-1:0] ofm_valid;
    logic          done_compute;
    logic          wr_ready;
    logic [31:0]   base_addr;

    logic [1:0]  sel_a, sel_b;
    logic [31:0] addr_a;
    logic [11:0] addr_b;
    logic        wen_a, wdv_a, busy_a, ovf_a;
    logic        wen_b, wdv_b, busy_b, ovf_b;

    ofm_writeback_sequencer u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .ofm_valid     (ofm_valid),
        .done_compute  (done_compute),
        .base_addr     (base_addr),
        .wr_ready      (wr_ready),
        .mux_sel       (sel_a),
        .addr_next_wr  (addr_a),
        .wr_en_next    (wen_a),
        .wr_data_valid (wdv_a),
        .busy          (busy_a),
        .overflow_err  (ovf_a)
    );

    ofm_writeback_sequencer #(
        .NUM_LANES (NL),
        .NUM_BEATS (3),
        .ADDR_W    (12),
        .DEPTH     (6)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .ofm_valid     (ofm_valid),
        .done_compute  (done_compute),
        .base_addr     (base_addr[11:0]),
        .wr_ready      (wr_ready),
        .mux_sel       (sel_b),
        .addr_next_wr  (addr_b),
        .wr_en_next    (wen_b),
        .wr_data_valid (wdv_b),
        .busy          (busy_b),
        .overflow_err  (ovf_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: in a burst or not, which beat of the group is presented,
    // how many words into the region the next write lands, and the flags.
    bit m_busy[2];
    int m_beat[2];
    int m_off[2];
    bit m_wdv[2];
    bit m_ovf[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_beat[k] = 0;
            m_off[k]  = 0;
            m_wdv[k]  = 1'b0;
            m_ovf[k]  = 1'b0;
        end
    endtask

    // Advance instance k across one clock edge with the inputs now driven.
    task automatic model_step(input int k, input int nb, input int dp);
        bit gs, accepted, final_beat;
        gs         = &ofm_valid;
        accepted   = m_busy[k] && wr_ready;
        final_beat = accepted && (m_beat[k] == nb - 1);
        if (done_compute) begin
            m_busy[k] = 1'b0;
            m_beat[k] = 0;
            m_off[k]  = 0;
            m_wdv[k]  = 1'b0;
            m_ovf[k]  = 1'b0;
        end else begin
            m_wdv[k] = final_beat;
            if (m_busy[k] && gs && !final_beat) m_ovf[k] = 1'b1;
            if (accepted) begin
                m_beat[k] = (m_beat[k] + 1) % nb;
                m_off[k]  = (m_off[k] + 1) % dp;
            end
            if (!m_busy[k] || final_beat) m_busy[k] = gs;
        end
    endtask

    task automatic check_inst(input int k, input string nm, input int aw,
                              input logic wen, input logic bsy, input logic [1:0] sel,
                              input logic [31:0] addr, input logic wdv, input logic ovf);
        logic [63:0] exp_addr;
        exp_addr = (64'(base_addr) + 64'(m_off[k])) & ((64'd1 << aw) - 64'd1);
        check_eq({nm, ".wr_en_next"},    64'(wen),  64'(m_busy[k]));
        check_eq({nm, ".busy"},          64'(bsy),  64'(m_busy[k]));
        check_eq({nm, ".mux_sel"},       64'(sel),  64'(m_beat[k]));
        check_eq({nm, ".addr_next_wr"},  64'(addr), exp_addr);
        check_eq({nm, ".wr_data_valid"}, 64'(wdv),  64'(m_wdv[k]));
        check_eq({nm, ".overflow_err"},  64'(ovf),  64'(m_ovf[k]));
    endtask

    task automatic check_all();
        check_inst(0, "a", 32, wen_a, busy_a, sel_a, addr_a, wdv_a, ovf_a);
        check_inst(1, "b", 12, wen_b, busy_b, sel_b, 32'(addr_b), wdv_b, ovf_b);
    endtask

    // ---------------- driver ----------------
    // Check the state produced by the previous edge, then drive the inputs
    // for the next edge and let the model predict its result.
    task automatic tick(input bit gs, input bit dn, input bit rdy);
        logic [NL-1:0] v;
        @(negedge clk);
        check_all();
        v = NL'($urandom);
        v[$urandom_range(0, NL - 1)] = 1'b0;
        ofm_valid    = gs ? '1 : v;
        done_compute = dn;
        wr_ready     = rdy;
        model_step(0, 4, 65536);
        model_step(1, 3, 6);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        ofm_valid    = '0;
        done_compute = 1'b0;
        wr_ready     = 1'b1;
        base_addr    = 32'h100;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        tick(0, 0, 1);

        // single group, sink always ready
        tick(1, 0, 1);
        repeat (5) tick(0, 0, 1);

        // sink stalls for two cycles on beat 1
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        repeat (4) tick(0, 0, 1);

        // back-to-back groups: new group on the last beat
        tick(1, 0, 1);
        repeat (3) tick(0, 0, 1);
        tick(1, 0, 1);
        repeat (5) tick(0, 0, 1);

        // abort at beat 2 with a coincident group start
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
        tick(1, 1, 1);
        repeat (2) tick(0, 0, 1);

        // overflow at beat 1, sticky across later groups, cleared by done
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(1, 0, 1);
        repeat (4) tick(0, 0, 1);
        tick(1, 0, 1);
        repeat (5) tick(0, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);

        // asynchronous reset in the middle of a burst with overflow set
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(1, 0, 1);
        @(negedge clk);
        check_all();
        ofm_valid    = '0;
        done_compute = 1'b0;
        wr_ready     = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit gs, dn, rdy;
            gs  = ($urandom_range(0, 5) == 0);
            dn  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if (dn && $urandom_range(0, 1) == 1) base_addr = $urandom;
            tick(gs, dn, rdy);
        end

        @(negedge clk);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofm_writeback_sequencer.md
Name: ofm_writeback_sequencer

Overview:
Parametrised successor of the MB-block data controller. Detects a complete OFM group (all lanes valid) and serialises it as NUM_BEATS write beats into the next layer's RAM. For each beat it drives the output mux select, the write address, the write enable and an end-of-group pulse. Adds sink backpressure, address wrap within a layer region, back-to-back groups, abort on done_compute and an overflow error flag.

Parameters:
NUM_LANES, 16, OFM lanes; a group starts when all lanes are valid
NUM_BEATS, 4, beats per group (>=2); the mux select counts 0..NUM_BEATS-1
ADDR_W, 32, write address width
DEPTH, 65536, region size in words; the offset wraps to 0 after DEPTH-1
SEL_W, $clog2(NUM_BEATS), localparam, mux select width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ofm_valid  in  NUM_LANES  per-lane OFM valid; grp_start = &ofm_valid
done_compute  in  1  layer finished; clears the offset and aborts any burst
base_addr  in  ADDR_W  region base; must be stable during a layer
wr_ready  in  1  sink accepts the beat this cycle
mux_sel  out  SEL_W  selects the OFM slice for the current beat
addr_next_wr  out  ADDR_W  base_addr + offset (combinational add of the registered offset)
wr_en_next  out  1  beat presented; high exactly while state==DRAIN
wr_data_valid  out  1  one-cycle pulse after the last beat of a group is accepted
busy  out  1  state==DRAIN
overflow_err  out  1  sticky; a group was lost

Behaviour:
- Reset values: state IDLE, mux_sel 0, offset 0, wr_data_valid 0, overflow_err 0. As a result wr_en_next=0, busy=0 and addr_next_wr=base_addr.
- Beat accept: acc = wr_en_next & wr_ready. last = acc & (mux_sel==NUM_BEATS-1).
- State IDLE:
  - grp_start & !done_compute -> DRAIN, with mux_sel=0.
  - wr_en_next rises on the cycle after grp_start (1-cycle latency).
- State DRAIN:
  - On acc: mux_sel+1 and offset+1. When offset==DEPTH-1 it wraps to 0.
  - When wr_ready=0: mux_sel, offset and state all hold, and wr_en_next stays high.
  - On last: mux_sel->0 and wr_data_valid=1 on the next cycle.
  - If grp_start is also high on the last cycle, stay in DRAIN (back-to-back, no bubble). Otherwise go to IDLE.
- done_compute (any state, highest priority):
  - Next cycle: offset=0, mux_sel=0, state=IDLE, overflow_err cleared.
  - wr_data_valid=0, even if the same cycle was last.
  - A beat accepted in that same cycle counts as written, but the offset is not incremented.
- overflow_err: set when grp_start is high in DRAIN on a cycle that is not last and has no done_compute. Cleared only by rst or done_compute. The lost group is dropped and the burst in flight continues.
- grp_start is treated as a one-cycle event from upstream. A held level re-triggers after each group completes.
- Width rules:
  - The offset counter is $clog2(DEPTH) bits; the address add truncates to ADDR_W.
  - mux_sel never exceeds NUM_BEATS-1, including when NUM_BEATS is not a power of 2.
- Reset mid-burst: all state is cleared immediately (asynchronous). wr_en_next drops without a clock edge.

Decomposition:
- Shared package: state encoding (IDLE=0, DRAIN=1) and default parameter constants shared with the layer controller.
- One sub-module is natural: wrap_counter, a parametrised modulo counter with enable, sync clear and a terminal flag. Instantiate it twice: once for the beat counter (modulo NUM_BEATS) and once for the address offset (modulo DEPTH).

Test Plan:
1. Defaults, base_addr=0x100, wr_ready=1, one grp_start pulse at cycle 0 -> cycles 1-4: wr_en_next=1, mux_sel=0,1,2,3, addr=0x100..0x103; cycle 5: wr_data_valid=1, busy=0.
2. wr_ready=0 on cycles 2-3 of the same burst -> mux_sel holds 1 and addr holds 0x101 for 2 extra cycles; the burst ends at cycle 7 and wr_data_valid pulses at cycle 7.
3. grp_start on the last-beat cycle of the first group -> the second group's mux_sel=0 follows mux_sel=3 with no gap; addr continues at 0x104; wr_data_valid pulses once per group.
4. DEPTH=8, 3 groups of 4 beats -> the 3rd group's addrs are base+0..3 (wrap after offset 7).
5. done_compute at mux_sel=2 mid-burst -> next cycle: busy=0, mux_sel=0, addr=base_addr, no wr_data_valid. A grp_start in the same cycle as done_compute is ignored.
6. grp_start at mux_sel=1 during DRAIN -> overflow_err=1 and stays set through later groups; the current burst completes. done_compute clears it; rst asserted mid-burst clears all outputs asynchronously.
